// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shared multiplier: accepts one op,
// issues it, waits for the result and holds it on the writeback bus until taken.
module mul_arbiter #(
  parameter int TAG_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [31:0]      req0_a_i,
  input  logic [31:0]      req0_b_i,
  input  logic [1:0]       req0_op_i,
  input  logic [TAG_W-1:0] req0_tag_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [31:0]      req1_a_i,
  input  logic [31:0]      req1_b_i,
  input  logic [1:0]       req1_op_i,
  input  logic [TAG_W-1:0] req1_tag_i,
  output logic             mul_valid_o,
  output logic [31:0]      mul_a_o,
  output logic [31:0]      mul_b_o,
  output logic [1:0]       mul_op_o,
  input  logic [31:0]      mul_result_i,
  input  logic             mul_vld_i,
  output logic             wb_valid_o,
  output logic [31:0]      wb_data_o,
  output logic [TAG_W-1:0] wb_tag_o,
  input  logic             wb_ready_i,
  input  logic             flush_i,
  output logic             busy_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             r_lastGrant;
  logic             r_kill;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [1:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [31:0]      r_data;
  logic             w_grant1;
  logic             w_accept;
  logic             w_killNow;

  // Requester 1 wins when it is alone, or on contention when requester 0 was served last.
  assign w_grant1  = req1_valid_i && (!req0_valid_i || !r_lastGrant);
  assign w_accept  = (r_state == IDLE) && !flush_i && (req0_valid_i || req1_valid_i);
  assign w_killNow = r_kill || flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = ISSUE;
      ISSUE:   w_nextState = WAIT;
      WAIT:    if (mul_vld_i) w_nextState = w_killNow ? IDLE : HOLD;
      HOLD:    if (flush_i || wb_ready_i) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    req0_ready_o = w_accept && !w_grant1;
    req1_ready_o = w_accept && w_grant1;
    mul_valid_o  = (r_state == ISSUE);
    wb_valid_o   = (r_state == HOLD);
    busy_o       = (r_state != IDLE);
  end

  // The kill flag remembers a flush that hit an op already handed to the multiplier.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_kill      <= 1'b0;
      r_lastGrant <= 1'b1;
    end else begin
      if (w_accept) begin
        r_lastGrant <= w_grant1;
      end
      if (r_state == WAIT && mul_vld_i) begin
        r_kill <= 1'b0;
      end else if ((r_state == ISSUE || r_state == WAIT) && flush_i) begin
        r_kill <= 1'b1;
      end else if (r_state == IDLE) begin
        r_kill <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_a   <= w_grant1 ? req1_a_i   : req0_a_i;
      r_b   <= w_grant1 ? req1_b_i   : req0_b_i;
      r_op  <= w_grant1 ? req1_op_i  : req0_op_i;
      r_tag <= w_grant1 ? req1_tag_i : req0_tag_i;
    end
    if (r_state == WAIT && mul_vld_i && !w_killNow) begin
      r_data <= mul_result_i;
    end
  end

  assign mul_a_o   = r_a;
  assign mul_b_o   = r_b;
  assign mul_op_o  = r_op;
  assign wb_data_o = r_data;
  assign wb_tag_o  = r_tag;

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter TAG_W, default 6: width of the request/writeback tag (ROB index).
REQ-002 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous and active-high.
REQ-004 req0_valid_i / req1_valid_i  in  1 each  requester N has a multiply op pending.
REQ-005 req0_ready_o / req1_ready_o  out  1 each  op from requester N is accepted this cycle.
REQ-006 reqN_a_i, reqN_b_i  in  32 each  operands; reqN_op_i  in  2  opcode; reqN_tag_i  in  TAG_W  tag.
REQ-007 mul_valid_o  out  1  one-cycle start pulse to the multiplier.
REQ-008 mul_a_o, mul_b_o  out  32 each; mul_op_o  out  2: registered operands/opcode, stable from the start pulse until the result returns.
REQ-009 mul_result_i  in  32; mul_vld_i  in  1: multiplier result and one-cycle done pulse.
REQ-010 wb_valid_o  out  1; wb_data_o  out  32; wb_tag_o  out  TAG_W: writeback to result bus.
REQ-011 wb_ready_i  in  1  result bus accepts the writeback this cycle.
REQ-012 flush_i  in  1  pipeline flush; kills any accepted-but-not-written-back op.
REQ-013 busy_o  out  1  high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, ISSUE, WAIT, HOLD with one op outstanding at most.
REQ-015 In IDLE with flush_i low, reqN_ready_o SHALL be high combinationally for exactly the granted requester, and low for the other requester.
REQ-016 Grant: single valid requester wins; if both are valid, the requester not granted last wins (round-robin); last-grant pointer updates only on acceptance.
REQ-017 On acceptance the block SHALL register a, b, op, tag of the winner and move to ISSUE.
REQ-018 In ISSUE, mul_valid_o SHALL be high for exactly one cycle; next state WAIT.
REQ-019 In WAIT, on mul_vld_i the block SHALL capture mul_result_i into wb_data_o and go to HOLD; any multiplier latency >= 1 cycle after the start pulse SHALL work.
REQ-020 In HOLD, wb_valid_o SHALL be high with data/tag stable until wb_ready_i; on wb_ready_i go to IDLE (no new grant in that same cycle).
REQ-021 Opcode and operands SHALL pass to the multiplier unmodified; no arithmetic in this block.
REQ-022 flush_i in IDLE SHALL suppress both ready outputs; no acceptance occurs.
REQ-023 flush_i in ISSUE SHALL still emit the start pulse, set a kill flag, and proceed to WAIT.
REQ-024 flush_i in WAIT SHALL set the kill flag; when mul_vld_i arrives with the flag set (including flush_i and mul_vld_i in the same cycle), the result SHALL be discarded, the flag cleared, and state return to IDLE.
REQ-025 flush_i in HOLD SHALL drop wb_valid_o on the next cycle and return to IDLE, even if wb_ready_i is high in the same cycle.
REQ-026 mul_vld_i outside WAIT SHALL be ignored.
REQ-027 reqN_valid_i low in a cycle SHALL never produce reqN_ready_o high.

Reset
REQ-028 rst_i high SHALL immediately force state IDLE, and force mul_valid_o, wb_valid_o, busy_o, and the kill flag to 0.
REQ-029 Reset SHALL set the last-grant pointer to requester 1 so requester 0 wins the first contention.
REQ-030 Data/tag registers need no reset; reset mid-operation SHALL abandon the op with no writeback.

Verification
REQ-031 Both requesters valid after reset: req0 (a=7, b=6, op=00, tag=3) and req1 (a=5, b=5, tag=9) -> req0 accepted first, wb 42/tag 3; then req1 accepted, wb 25/tag 9.
REQ-032 Single op with the multiplier model at 3-cycle latency -> mul_valid_o pulses once, wb_valid_o rises 1 cycle after mul_vld_i, and busy_o stays high throughout.
REQ-033 wb_ready_i held low for 5 cycles in HOLD -> wb_valid_o, wb_data_o, and wb_tag_o stay constant, and reqN_ready_o stays low.
REQ-034 flush_i pulsed in WAIT -> mul_vld_i result is discarded, wb_valid_o never rises, and IDLE is reached the cycle after mul_vld_i.
REQ-035 flush_i coincident with wb_ready_i in HOLD -> no double writeback, and IDLE is reached the next cycle.
REQ-036 rst_i asserted asynchronously mid-WAIT -> outputs clear without a clock edge, and the late mul_vld_i is ignored.
